// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array front end.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    localparam int FEEDER_CNT_W = 16;

endpackage

// File: rtl/systolic_delay_line.sv
// Enable-gated shift register: DEPTH+1 stages, so DEPTH=0 is a single output register.
module systolic_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    localparam int CHAIN_W = (DEPTH + 1) * W;

    // Stage k lives at [k*W +: W]; new data always enters stage 0.
    logic [CHAIN_W-1:0] chain_q, chain_d;

    always_comb begin
        // NOTE: hold is the default so the enable-low path never infers a latch.
        chain_d = chain_q;
        if (en_i) begin
            chain_d = (chain_q << W) | CHAIN_W'(d_i);
        end
    end

    // NOTE: the chain is a handful of flops, not a RAM, so clearing it on reset is cheap and required.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            chain_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[DEPTH*W +: W];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews row vectors into a diagonal wavefront for the systolic array west edge.
// Optional beat/stall counters are built only when SYSTOLIC_FEEDER_STATS_EN is defined.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [N*DW-1:0]         s_data_i,
    input  logic                    s_last_i,
    input  logic                    stall_i,
    output logic                    a_en_o,
    output logic [N*DW-1:0]         a_data_o,
    output logic [N-1:0]            a_valid_o,
    output logic                    done_o,
    output logic [FEEDER_CNT_W-1:0] beats_o,
    output logic [FEEDER_CNT_W-1:0] stalls_o
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             accept;
    logic [N*DW-1:0]  lane_data;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        s_ready_o   = 1'b0;
        accept      = 1'b0;
        a_en_o      = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                s_ready_o = !stall_i;
                accept    = s_valid_i & !stall_i;
                a_en_o    = accept;
                if (accept) begin
                    if (!s_last_i) begin
                        state_d = STREAM;
                    end else if (N == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = CNT_W'(N - 1);
                    end
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    a_en_o      = 1'b1;
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    if (flush_cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign done_o = (state_q == DONE);

    // Flush advances inject a zero element with valid low into every lane.
    assign lane_data = accept ? s_data_i : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW:0] lane_q;

        systolic_delay_line #(
            .DEPTH(i),
            .W    (DW + 1)
        ) u_dly (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .en_i (a_en_o),
            .d_i  ({accept, lane_data[i*DW +: DW]}),
            .q_o  (lane_q)
        );

        assign a_valid_o[i]        = lane_q[DW];
        assign a_data_o[i*DW +: DW] = lane_q[DW-1:0];
    end

`ifdef SYSTOLIC_FEEDER_STATS_EN
    logic [FEEDER_CNT_W-1:0] beats_q, beats_d;
    logic [FEEDER_CNT_W-1:0] stalls_q, stalls_d;

    always_comb begin
        beats_d  = beats_q;
        stalls_d = stalls_q;
        if (accept && (beats_q != '1)) begin
            beats_d = beats_q + FEEDER_CNT_W'(1);
        end
        if (stall_i && (s_valid_i || (state_q == FLUSH)) && (stalls_q != '1)) begin
            stalls_d = stalls_q + FEEDER_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            beats_q  <= beats_d;
            stalls_q <= stalls_d;
        end
    end

    assign beats_o  = beats_q;
    assign stalls_o = stalls_q;
`else
    assign beats_o  = '0;
    assign stalls_o = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: fixed vector table, corner sequences
// and a slot-history reference model checked every cycle.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int W  = N * DW;

    logic          clk_i     = 1'b0;
    logic          rst_i     = 1'b0;
    logic          s_valid_i = 1'b0;
    logic          s_last_i  = 1'b0;
    logic          stall_i   = 1'b0;
    logic [W-1:0]  s_data_i  = '0;
    logic          s_ready_o, a_en_o, done_o;
    logic [W-1:0]  a_data_o;
    logic [N-1:0]  a_valid_o;
    logic [15:0]   beats_o, stalls_o;

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_data_i (s_data_i),
        .s_last_i (s_last_i),
        .stall_i  (stall_i),
        .a_en_o   (a_en_o),
        .a_data_o (a_data_o),
        .a_valid_o(a_valid_o),
        .done_o   (done_o),
        .beats_o  (beats_o),
        .stalls_o (stalls_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every advance appends one slot; lane i shows the slot i advances back.
    typedef struct {
        logic [W-1:0] d;
        bit           v;
    } slot_t;

    slot_t hist[$];
    int    flush_left = 0;
    bit    done_now   = 1'b0;
    int    m_beats    = 0;
    int    m_stalls   = 0;

    logic         smp_ready, smp_en, smp_done, smp_acc;
    logic [N-1:0] smp_av;
    logic [W-1:0] smp_ad;

    task automatic model_reset();
        hist.delete();
        flush_left = 0;
        done_now   = 1'b0;
        m_beats    = 0;
        m_stalls   = 0;
    endtask

    // Entered at posedge+1 with inputs applied; samples at the negedge, then crosses one edge.
    task automatic cycle();
        bit           rdy, acc, fadv, en, done_next;
        logic [W-1:0] ed;
        logic [N-1:0] ev;
        slot_t        s;
        int           j;
        #4;
        rdy  = !stall_i && (flush_left == 0) && !done_now;
        acc  = s_valid_i && rdy;
        fadv = (flush_left > 0) && !stall_i;
        en   = acc || fadv;
        ed   = '0;
        ev   = '0;
        for (int i = 0; i < N; i++) begin
            j = hist.size() - 1 - i;
            if (j >= 0) begin
                ed[i*DW +: DW] = hist[j].d[i*DW +: DW];
                ev[i]          = hist[j].v;
            end
        end
        smp_ready = s_ready_o;
        smp_en    = a_en_o;
        smp_done  = done_o;
        smp_av    = a_valid_o;
        smp_ad    = a_data_o;
        smp_acc   = acc;
        check("mdl_ready", s_ready_o, rdy);
        check("mdl_a_en",  a_en_o,    en);
        check("mdl_done",  done_o,    done_now);
        check("mdl_valid", a_valid_o, ev);
        check("mdl_data",  a_data_o,  ed);
`ifdef SYSTOLIC_FEEDER_STATS_EN
        check("mdl_beats",  beats_o,  m_beats);
        check("mdl_stalls", stalls_o, m_stalls);
`else
        check("beats_off",  beats_o,  0);
        check("stalls_off", stalls_o, 0);
`endif
        if (stall_i && (s_valid_i || flush_left > 0) && m_stalls < 65535) m_stalls++;
        if (acc && m_beats < 65535) m_beats++;
        if (en) begin
            s.d = acc ? s_data_i : '0;
            s.v = acc;
            hist.push_back(s);
            if (hist.size() > N) void'(hist.pop_front());
        end
        done_next = fadv && (flush_left == 1);
        if (acc && s_last_i) flush_left = N - 1;
        else if (fadv)       flush_left--;
        done_now = done_next;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        do begin
            cycle();
            cycles++;
        end while (!smp_done && cycles < limit);
        check("done_seen", smp_done, 1'b1);
    endtask

    typedef struct {
        bit           vld, lst, stl;
        logic [W-1:0] data;
        bit           rdy, en, dn;
        logic [N-1:0] av;
        logic [W-1:0] ad;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, lat, base, guard, beat, mtx;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h04030201, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h00000001};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0010, 32'h00000200};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0100, 32'h00030000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h04000000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h13121110, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h04000000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h23222120, 1'b1, 1'b1, 1'b0, 4'b0001, 32'h00000010};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h33323130, 1'b1, 1'b1, 1'b0, 4'b0011, 32'h00001120};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0111, 32'h00122130};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b1110, 32'h13223100};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h23320000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h33000000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h33000000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h33000000};

        // Reset state
        #12;
        check("rst_ready", s_ready_o, 1'b1);
        check("rst_a_en",  a_en_o,    1'b0);
        check("rst_done",  done_o,    1'b0);
        check("rst_valid", a_valid_o, '0);
        check("rst_data",  a_data_o,  '0);
        check("rst_beats", beats_o,   '0);
        check("rst_stalls", stalls_o, '0);
        #8 rst_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;

        // Single-beat matrix, then three back-to-back beats with flush
        for (int r = 0; r < 14; r++) begin
            s_valid_i = vecs[r].vld;
            s_last_i  = vecs[r].lst;
            stall_i   = vecs[r].stl;
            s_data_i  = vecs[r].data;
            cycle();
            check($sformatf("vec%0d_ready", r), smp_ready, vecs[r].rdy);
            check($sformatf("vec%0d_a_en",  r), smp_en,    vecs[r].en);
            check($sformatf("vec%0d_done",  r), smp_done,  vecs[r].dn);
            check($sformatf("vec%0d_valid", r), smp_av,    vecs[r].av);
            check($sformatf("vec%0d_data",  r), smp_ad,    vecs[r].ad);
        end

        // Five-cycle stall in the middle of FLUSH
        s_valid_i = 1'b1; s_last_i = 1'b1; s_data_i = $urandom;
        cycle();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        cycle();
        base = m_stalls;
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_ready", smp_ready, 1'b0);
            check("stall_a_en",  smp_en,    1'b0);
        end
        stall_i = 1'b0;
        wait_done(20, w);
        lat = 2 + 5 + w - 1;
        check("stall_done_latency", lat, 4 + 5);
`ifdef SYSTOLIC_FEEDER_STATS_EN
        check("stall_count", stalls_o, base + 5);
`endif

        // Valid while stalled in IDLE, then release
        base = m_beats;
        s_valid_i = 1'b1; s_last_i = 1'b1; s_data_i = $urandom; stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("idle_stall_ready", smp_ready, 1'b0);
            check("idle_stall_a_en",  smp_en,    1'b0);
        end
`ifdef SYSTOLIC_FEEDER_STATS_EN
        check("idle_stall_beats", beats_o, base);
`endif
        stall_i = 1'b0;
        cycle();
        check("release_accept", smp_en, 1'b1);
        s_valid_i = 1'b0; s_last_i = 1'b0;
        wait_done(20, w);

        // Asynchronous reset while lane 2 holds a valid element
        s_valid_i = 1'b1; s_last_i = 1'b1; s_data_i = 32'hDDCCBBAA;
        cycle();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        cycle();
        cycle();
        check("pre_rst_lane2", a_valid_o[2], 1'b1);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check("arst_valid", a_valid_o, '0);
        check("arst_data",  a_data_o,  '0);
        check("arst_done",  done_o,    1'b0);
        check("arst_ready", s_ready_o, 1'b1);
        check("arst_a_en",  a_en_o,    1'b0);
        @(posedge clk_i);
        #1;
        check("arst_no_done", done_o, 1'b0);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b1; s_last_i = 1'b1; s_data_i = 32'h04030201;
        cycle();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        wait_done(20, w);
        check("post_rst_latency", w, 4);

        // Three random 4x4 matrices, back-to-back, with random upstream gaps
        beat = 0; mtx = 0; guard = 0;
        while (mtx < 3 && guard < 300) begin
            s_valid_i = ($urandom_range(0, 3) != 0);
            s_last_i  = (beat == N - 1);
            s_data_i  = $urandom;
            cycle();
            guard++;
            if (smp_acc) begin
                if (beat == N - 1) begin
                    beat = 0;
                    mtx++;
                end else begin
                    beat++;
                end
            end
        end
        check("matrices_accepted", mtx, 3);
        s_valid_i = 1'b0; s_last_i = 1'b0;
        wait_done(20, w);

        // Random stress including stalls and arbitrary last flags
        for (int k = 0; k < 400; k++) begin
            s_valid_i = $urandom_range(0, 1);
            s_last_i  = ($urandom_range(0, 3) == 0);
            stall_i   = ($urandom_range(0, 3) == 0);
            s_data_i  = $urandom;
            cycle();
        end
        s_valid_i = 1'b0; s_last_i = 1'b0; stall_i = 1'b0;
        for (int k = 0; k < 8; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
